// File: rtl/test_pkg.sv
// test_pkg: shared state type, counter width and run defaults for the test read/write generators.
package test_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int CNT_W     = 16;
    localparam int DEF_BURST = 1;
    localparam int DEF_TIME  = 10;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return v + CNT_W'(v != '1);
    endfunction

endpackage

// File: rtl/test_rd_if.sv
// test_rd_if: read-port handshake between the traffic generator and the memory.
interface test_rd_if #(
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_req, input rd_valid, input rd_data);
    modport slave  (input rd_req, output rd_valid, output rd_data);
endinterface

// File: rtl/start_edge_sync.sv
// start_edge_sync: brings an asynchronous start level into clk and emits a one-cycle rising-edge pulse.
module start_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (rst) {s1_q, s2_q} <= '0;
        else     {s1_q, s2_q} <= {async_i, s1_q};
    end

    assign pulse_o = s1_q & ~s2_q;
endmodule

// File: rtl/test_rd.sv
// test_rd: directed read-traffic generator; issues BURST spaced reads and checks each word against SEED+k.
module test_rd
    import test_pkg::*;
#(
    parameter int BURST   = DEF_BURST,
    parameter int TIME    = DEF_TIME,
    parameter int DATA_W  = 16,
    parameter int SEED    = 0,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    test_rd_if.master        rd,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rsp_cnt
);
    localparam int SCH_W = $clog2(TIME);
    localparam int DRN_W = $clog2(TIMEOUT + 1);

    state_t            st_q;
    logic [SCH_W-1:0]  sch_q;
    logic [DRN_W-1:0]  drn_q;
    logic [CNT_W-1:0]  req_q, out_q, out_d, err_cnt_q, rsp_cnt_q;
    logic              rd_req_q, busy_q, done_q, err_flag_q, timeout_q;
    logic              launch, issue, acc, bad;
    logic [DATA_W-1:0] exp_w;

    start_edge_sync u_sync (.clk(clk), .rst(rst), .async_i(start), .pulse_o(launch));

    // Outstanding is counted at issue time so DRAIN already sees the final request.
    assign issue = st_q == RUN && sch_q == SCH_W'(TIME - 1);
    assign acc   = rd.rd_valid && (st_q == RUN || st_q == DRAIN) && out_q != '0;
    assign exp_w = DATA_W'(SEED) + DATA_W'(rsp_cnt_q);
    assign bad   = rd.rd_valid && (!acc || rd.rd_data != exp_w);
    assign out_d = out_q + CNT_W'(issue) - CNT_W'(acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= IDLE;
            sch_q      <= '0;
            drn_q      <= '0;
            req_q      <= '0;
            out_q      <= '0;
            err_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_flag_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rd_req_q <= issue;
            if (launch && (st_q == IDLE || st_q == DONE)) begin
                st_q       <= RUN;
                sch_q      <= '0;
                drn_q      <= '0;
                req_q      <= '0;
                out_q      <= '0;
                err_cnt_q  <= '0;
                rsp_cnt_q  <= '0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_flag_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                out_q <= out_d;
                if (acc) rsp_cnt_q <= rsp_cnt_q + 1'b1;
                if (bad) begin
                    err_cnt_q  <= sat_inc(err_cnt_q);
                    err_flag_q <= 1'b1;
                end
                case (st_q)
                    RUN: begin
                        sch_q <= issue ? '0 : sch_q + 1'b1;
                        if (issue) begin
                            req_q <= req_q + 1'b1;
                            if (req_q == CNT_W'(BURST - 1)) begin
                                st_q  <= DRAIN;
                                drn_q <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_q == '0 || drn_q == DRN_W'(TIMEOUT - 1)) begin
                            st_q   <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            if (out_q != '0) begin
                                timeout_q  <= 1'b1;
                                err_flag_q <= 1'b1;
                            end
                        end else begin
                            drn_q <= drn_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd.rd_req = rd_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_flag  = err_flag_q;
    assign timeout   = timeout_q;
    assign err_cnt   = err_cnt_q;
    assign rsp_cnt   = rsp_cnt_q;
endmodule
